spi_xfer: RTL and testbench

SPI_XFER -- requirements
Module: spi_xfer

---
 rtl/spi_xfer_pkg.sv | 16 +
 rtl/spi_xfer_tick.sv | 38 +++
 rtl/spi_xfer.sv | 114 +++++++++++
 tb/tb_spi_xfer.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/spi_xfer_pkg.sv
// Shared definitions for the SPI byte-transfer engine: state encoding,
// default divider and transfer geometry.
package spi_xfer_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_e;

    localparam int CLKDIV_DEFAULT = 2;
    localparam int DATA_W         = 8;
    localparam int XFER_TOGGLES   = 16;
    localparam int TOG_W          = $clog2(XFER_TOGGLES);
    localparam int DIV_W          = 8;

endpackage

// File: rtl/spi_xfer_tick.sv
// SCK half-period divider: emits a one-cycle tick every CLKDIV enabled cycles,
// restarting its count whenever a new transfer is loaded.
module spi_tick
    import spi_xfer_pkg::*;
#(
    parameter int CLKDIV = CLKDIV_DEFAULT
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    input  logic load_i,
    output logic tick_o
);

    localparam logic [DIV_W-1:0] RELOAD = DIV_W'(CLKDIV - 1);

    logic [DIV_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = RELOAD;
        end else if (en_i) begin
            cnt_d = (cnt_q == '0) ? RELOAD : cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = en_i && !load_i && (cnt_q == '0);

endmodule

// File: rtl/spi_xfer.sv
// SPI master byte engine (modes 0/2): shifts one byte out MSB first on MOSI
// while sampling the selected MISO line, then reports it on RX_DATA with DONE.
module spi_xfer
    import spi_xfer_pkg::*;
#(
    parameter int CLKDIV = CLKDIV_DEFAULT,
    parameter bit CPOL   = 1'b0
) (
    input  logic              CLK,
    input  logic              nRESET,
    input  logic              WR_STB,
    input  logic [DATA_W-1:0] WR_DATA,
    input  logic [1:0]        nSS,
    input  logic [2:0]        MISO,
    output logic              MOSI,
    output logic              SCK,
    output logic              BUSY,
    output logic              DONE,
    output logic [DATA_W-1:0] RX_DATA,
    output logic              OVR
);

    state_e            state_q, state_d;
    // Bit DATA_W..1 hold the outgoing byte; bit 0 parks the bit sampled on
    // the leading edge until the trailing edge shifts it in.
    logic [DATA_W:0]   shreg_q, shreg_d;
    logic [TOG_W-1:0]  tog_q, tog_d;
    logic              sck_q, sck_d;
    logic              mosi_q, mosi_d;
    logic              done_q, done_d;
    logic              ovr_q, ovr_d;
    logic [DATA_W-1:0] rx_q, rx_d;

    logic accept, tick, misox, leading, last;

    assign accept  = WR_STB && (state_q == IDLE);
    assign misox   = (MISO[0] & ~nSS[0]) | (MISO[1] & ~nSS[1]) | (MISO[2] & nSS[0] & nSS[1]);
    assign leading = ~tog_q[0];
    assign last    = (tog_q == TOG_W'(XFER_TOGGLES - 1));

    spi_tick #(.CLKDIV(CLKDIV)) u_tick (
        .clk_i  (CLK),
        .rst_ni (nRESET),
        .en_i   (state_q == XFER),
        .load_i (accept),
        .tick_o (tick)
    );

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        tog_d   = tog_q;
        sck_d   = sck_q;
        mosi_d  = mosi_q;
        done_d  = 1'b0;
        ovr_d   = ovr_q;
        rx_d    = rx_q;
        if (accept) begin
            state_d = XFER;
            shreg_d = {WR_DATA, 1'b0};
            mosi_d  = WR_DATA[DATA_W-1];
            tog_d   = '0;
            ovr_d   = 1'b0;
        end else begin
            if (WR_STB) begin
                ovr_d = 1'b1;
            end
            if ((state_q == XFER) && tick) begin
                sck_d = ~sck_q;
                tog_d = tog_q + 1'b1;
                if (leading) begin
                    shreg_d[0] = misox;
                end else if (last) begin
                    rx_d    = shreg_q[DATA_W-1:0];
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    shreg_d = {shreg_q[DATA_W-1:0], 1'b0};
                    mosi_d  = shreg_q[DATA_W-1];
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            state_q <= IDLE;
            shreg_q <= '0;
            tog_q   <= '0;
            sck_q   <= CPOL;
            mosi_q  <= 1'b0;
            done_q  <= 1'b0;
            ovr_q   <= 1'b0;
            rx_q    <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            tog_q   <= tog_d;
            sck_q   <= sck_d;
            mosi_q  <= mosi_d;
            done_q  <= done_d;
            ovr_q   <= ovr_d;
            rx_q    <= rx_d;
        end
    end

    assign MOSI    = mosi_q;
    assign SCK     = sck_q;
    assign BUSY    = (state_q == XFER);
    assign DONE    = done_q;
    assign RX_DATA = rx_q;
    assign OVR     = ovr_q;

endmodule

// File: tb/tb_spi_xfer.sv
// Directed bench for spi_xfer: instance A (CLKDIV=2, CPOL=0) and B (CLKDIV=1, CPOL=1).
module tb_spi_xfer;

    logic       clk = 1'b0;
    logic       nreset = 1'b1;
    logic       stb = 1'b0;
    logic       sel = 1'b0;
    logic       loop_en = 1'b0;
    logic [7:0] wdata = 8'h00;
    logic [1:0] nss = 2'b11;
    logic [2:0] miso_cfg = 3'b000;

    always #5 clk = ~clk;

    logic       stb_a, stb_b, mosi_a, mosi_b, sck_a, sck_b, busy_a, busy_b;
    logic       done_a, done_b, ovr_a, ovr_b;
    logic [7:0] rx_a, rx_b;
    logic [2:0] miso_a, miso_b;
    logic       mosi_s, sck_s, busy_s, done_s, ovr_s;
    logic [7:0] rx_s;

    assign stb_a  = stb & ~sel;
    assign stb_b  = stb & sel;
    assign miso_a = loop_en ? {2'b00, mosi_a} : miso_cfg;
    assign miso_b = loop_en ? {2'b00, mosi_b} : miso_cfg;
    assign mosi_s = sel ? mosi_b : mosi_a;
    assign sck_s  = sel ? sck_b  : sck_a;
    assign busy_s = sel ? busy_b : busy_a;
    assign done_s = sel ? done_b : done_a;
    assign ovr_s  = sel ? ovr_b  : ovr_a;
    assign rx_s   = sel ? rx_b   : rx_a;

    spi_xfer #(.CLKDIV(2), .CPOL(1'b0)) dut_a (
        .CLK(clk), .nRESET(nreset), .WR_STB(stb_a), .WR_DATA(wdata), .nSS(nss),
        .MISO(miso_a), .MOSI(mosi_a), .SCK(sck_a), .BUSY(busy_a), .DONE(done_a),
        .RX_DATA(rx_a), .OVR(ovr_a)
    );

    spi_xfer #(.CLKDIV(1), .CPOL(1'b1)) dut_b (
        .CLK(clk), .nRESET(nreset), .WR_STB(stb_b), .WR_DATA(wdata), .nSS(nss),
        .MISO(miso_b), .MOSI(mosi_b), .SCK(sck_b), .BUSY(busy_b), .DONE(done_b),
        .RX_DATA(rx_b), .OVR(ovr_b)
    );

    int n_chk = 0;
    int n_fail = 0;
    int cyc, tog, lead;
    logic [7:0] seen;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Called at a negedge: raises the strobe, then follows the transfer until
    // DONE is seen, returning at that negedge. Records MOSI at each leading edge.
    task automatic run_xfer(input logic [7:0] d, input int ovr_at, input int nss_at);
        logic prev, cpol;
        cpol  = sel;
        stb   = 1'b1;
        wdata = d;
        @(negedge clk);
        stb = 1'b0;
        chk("busy_after_accept", busy_s, 1);
        cyc = 0; tog = 0; lead = 0; seen = 8'h00; prev = cpol;
        for (int i = 0; i < 200; i++) begin
            if (sck_s != prev) begin
                tog++;
                if (sck_s != cpol) begin
                    lead++;
                    seen = {seen[6:0], mosi_s};
                end
                prev = sck_s;
            end
            if (done_s) break;
            @(negedge clk);
            cyc++;
            stb = (ovr_at != 0) && (cyc == ovr_at);
            if (stb) wdata = 8'h81;
            if ((nss_at != 0) && (cyc == nss_at)) nss = ~nss;
        end
        stb = 1'b0;
        chk("done_seen", done_s, 1);
        chk("busy_at_done", busy_s, 0);
    endtask

    typedef struct {
        logic [1:0] nss;
        logic       loop;
        logic [2:0] miso;
        logic [7:0] data;
        logic [7:0] exp_rx;
    } vec_t;

    vec_t vecs[8];
    int   dcount;

    initial begin
        vecs[0] = '{2'b10, 1'b1, 3'b000, 8'hA5, 8'hA5};
        vecs[1] = '{2'b11, 1'b0, 3'b100, 8'h00, 8'hFF};
        vecs[2] = '{2'b01, 1'b0, 3'b010, 8'h3C, 8'hFF};
        vecs[3] = '{2'b01, 1'b0, 3'b101, 8'hE7, 8'h00};
        vecs[4] = '{2'b00, 1'b0, 3'b100, 8'h5A, 8'h00};
        vecs[5] = '{2'b00, 1'b0, 3'b001, 8'h81, 8'hFF};
        vecs[6] = '{2'b11, 1'b0, 3'b011, 8'h7E, 8'h00};
        vecs[7] = '{2'b10, 1'b1, 3'b000, 8'h5A, 8'h5A};

        // Asynchronous reset, checked before any clock edge.
        #1 nreset = 1'b0;
        #1;
        chk("rst_sck_a", sck_a, 0);
        chk("rst_sck_b", sck_b, 1);
        chk("rst_mosi_a", mosi_a, 0);
        chk("rst_busy_a", busy_a, 0);
        chk("rst_done_a", done_a, 0);
        chk("rst_ovr_a", ovr_a, 0);
        chk("rst_rx_a", rx_a, 8'h00);
        chk("rst_rx_b", rx_b, 8'h00);
        @(negedge clk);
        nreset = 1'b1;
        repeat (2) @(negedge clk);

        sel = 1'b0;
        for (int v = 0; v < 8; v++) begin
            nss = vecs[v].nss; loop_en = vecs[v].loop; miso_cfg = vecs[v].miso;
            run_xfer(vecs[v].data, 0, 0);
            chk("vec_done_cycle", cyc, 32);
            chk("vec_toggles", tog, 16);
            chk("vec_sck_rises", lead, 8);
            chk("vec_mosi_bits", seen, vecs[v].data);
            chk("vec_rx", rx_a, vecs[v].exp_rx);
            chk("vec_ovr", ovr_a, 0);
            @(negedge clk);
            chk("vec_done_one_cycle", done_a, 0);
            chk("vec_sck_idle", sck_a, 0);
            chk("vec_rx_stable", rx_a, vecs[v].exp_rx);
        end

        // nSS switched from slave 0 to slave 1 before the fifth sample.
        nss = 2'b10; loop_en = 1'b0; miso_cfg = 3'b010;
        run_xfer(8'h00, 0, 16);
        chk("nss_switch_rx", rx_a, 8'h0F);
        @(negedge clk);

        // Overrun: second strobe ignored mid-transfer.
        nss = 2'b10; loop_en = 1'b1;
        run_xfer(8'h3C, 10, 0);
        chk("ovr_mosi_bits", seen, 8'h3C);
        chk("ovr_rx", rx_a, 8'h3C);
        chk("ovr_done_cycle", cyc, 32);
        chk("ovr_set", ovr_a, 1);
        @(negedge clk);
        chk("ovr_sticky", ovr_a, 1);

        // Back-to-back: second strobe coincides with the first DONE.
        run_xfer(8'h12, 0, 0);
        chk("ovr_cleared", ovr_a, 0);
        chk("b2b_rx1", rx_a, 8'h12);
        run_xfer(8'h34, 0, 0);
        chk("b2b_done_spacing", cyc, 32);
        chk("b2b_rx2", rx_a, 8'h34);
        chk("b2b_mosi_bits", seen, 8'h34);
        @(negedge clk);

        // Reset in the middle of a transfer that has OVR set.
        stb = 1'b1; wdata = 8'hC3;
        @(negedge clk);
        stb = 1'b0;
        repeat (5) @(negedge clk);
        stb = 1'b1;
        @(negedge clk);
        stb = 1'b0;
        repeat (6) @(negedge clk);
        chk("pre_rst_busy", busy_a, 1);
        chk("pre_rst_ovr", ovr_a, 1);
        #2 nreset = 1'b0;
        #1;
        chk("mid_rst_sck", sck_a, 0);
        chk("mid_rst_mosi", mosi_a, 0);
        chk("mid_rst_busy", busy_a, 0);
        chk("mid_rst_done", done_a, 0);
        chk("mid_rst_ovr", ovr_a, 0);
        chk("mid_rst_rx", rx_a, 8'h00);
        @(negedge clk);
        nreset = 1'b1;
        dcount = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done_a || busy_a) dcount++;
        end
        chk("post_rst_no_activity", dcount, 0);
        chk("post_rst_rx", rx_a, 8'h00);

        // Instance B: CLKDIV=1, CPOL=1.
        sel = 1'b1;
        chk("b_sck_idle_high", sck_b, 1);
        nss = 2'b10; loop_en = 1'b1;
        run_xfer(8'hC3, 0, 0);
        chk("b_done_cycle", cyc, 16);
        chk("b_toggles", tog, 16);
        chk("b_sck_falls", lead, 8);
        chk("b_mosi_bits", seen, 8'hC3);
        chk("b_rx", rx_b, 8'hC3);
        chk("b_sck_back_high", sck_b, 1);
        @(negedge clk);
        nss = 2'b11; loop_en = 1'b0; miso_cfg = 3'b100;
        run_xfer(8'h00, 0, 0);
        chk("b_aux_rx", rx_b, 8'hFF);
        chk("b_aux_mosi", seen, 8'h00);
        @(negedge clk);
        chk("b_done_one_cycle", done_b, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
